prog_counter: RTL and testbench

Parametrised, loadable up/down counter with programmable terminal value, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It generalises the free-running 4-bit counter into the general event/timebase counter used by the datapath and control blocks. It sits between a local timing source (enable strobe) and any consumer that needs a count value or a period-boundary pulse.

---
 rtl/prog_counter.sv | 73 +++++++
 tb/tb_prog_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Loadable up/down counter with programmable terminal value, wrap/saturate,
// terminal-count pulse and sticky overflow. Optional prescaler: COUNTER_PRESCALE_EN.
module prog_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (2**WIDTH)-1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic             step;
  logic             at_bnd;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_sat;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PLAST = PW'(PRESCALE-1);

  logic [PW-1:0] pre;

  // Only the en cycle that completes a prescale period is a step.
  assign step = en && (pre == PLAST);

  always_ff @(posedge clk) begin
    if (reset || load)  pre <= '0;
    else if (en)        pre <= step ? '0 : pre + 1'b1;
  end
`else
  localparam int unused_prescale = PRESCALE;
  assign step = en;
`endif

  always_comb begin
    at_bnd    = up_dn ? (count == MAXV) : (count == '0);
    count_nxt = count;
    if (at_bnd)     count_nxt = sat_mode ? count : (up_dn ? '0 : MAXV);
    else if (up_dn) count_nxt = count + 1'b1;
    else            count_nxt = count - 1'b1;
    load_sat  = (load_val > MAXV) ? MAXV : load_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_sat;
      tc    <= 1'b0;
      if (ovf_clr) ovf <= 1'b0;
    end else begin
      tc <= step && at_bnd;
      if (step) count <= count_nxt;
      // A boundary hit on the same edge as a clear keeps the flag set.
      if (step && at_bnd) ovf <= 1'b1;
      else if (ovf_clr)   ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter (WIDTH=4, MAX_VAL=9): directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_prog_counter;

  localparam int W  = 4;
  localparam int MX = 9;
`ifdef COUNTER_PRESCALE_EN
  localparam int P  = 3;
`else
  localparam int P  = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1, en = 1'b0, load = 1'b0, up_dn = 1'b1;
  logic         sat_mode = 1'b0, ovf_clr = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc, ovf;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // behavioural model state
  int mc = 0, mp = 0;
  bit mt = 0, mo = 0;

  prog_counter #(.WIDTH(W), .MAX_VAL(MX), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
    .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: en cycles are counted modulo P; a step moves the count around the
  // ring 0..MX, or holds at the boundary in saturate mode.
  always @(posedge clk) begin
    bit stp, bnd;
    if (reset) begin
      mc = 0; mt = 0; mo = 0; mp = 0;
    end else if (load) begin
      mc = (int'(load_val) > MX) ? MX : int'(load_val);
      mt = 0; mp = 0;
      if (ovf_clr) mo = 0;
    end else begin
      stp = 0;
      if (en) begin
        mp  = (mp + 1) % P;
        stp = (mp == 0);
      end
      bnd = stp && (up_dn ? (mc == MX) : (mc == 0));
      if (stp && !(bnd && sat_mode))
        mc = up_dn ? (mc + 1) % (MX + 1) : (mc + MX) % (MX + 1);
      mt = bnd;
      if (bnd) mo = 1;
      else if (ovf_clr) mo = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_count", int'(count), mc);
      chk("cyc_tc",    int'(tc),    int'(mt));
      chk("cyc_ovf",   int'(ovf),   int'(mo));
    end
  end

  task automatic cyc(input bit r, input bit e, input bit l, input int lv,
                     input bit u, input bit s, input bit c);
    reset = r; en = e; load = l; load_val = W'(lv);
    up_dn = u; sat_mode = s; ovf_clr = c;
    @(posedge clk); #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk_on = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_tc",    int'(tc),    0);
    chk("rst_ovf",   int'(ovf),   0);

`ifndef COUNTER_PRESCALE_EN
    // count 1..9,0,1,2 with a single tc at the wrap
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, 0, 1, 0, 0);
      chk("up_count", int'(count), (i + 1) % 10);
      chk("up_model", mc,          (i + 1) % 10);
      chk("up_tc",    int'(tc),    (i == 9) ? 1 : 0);
      chk("up_ovf",   int'(ovf),   (i >= 9) ? 1 : 0);
    end
`else
    // step every third en cycle; two idle cycles delay the next step
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 1, 0, 0, 1, 0, 0);
      chk("pre_count", int'(count), k / 3);
      chk("pre_model", mc,          k / 3);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("pre_idle", int'(count), 2);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("pre_mid", int'(count), 2);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("pre_step", int'(count), 3);
`endif

    // out-of-range load clamps to MAX_VAL, en ignored
    cyc(0, 1, 1, 15, 1, 0, 0);
    chk("load_clamp", int'(count), 9);
    chk("load_model", mc,          9);
    chk("load_tc",    int'(tc),    0);

`ifndef COUNTER_PRESCALE_EN
    cyc(0, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 1, 0);
      chk("sat_count", int'(count), 0);
      chk("sat_tc",    int'(tc),    1);
      chk("sat_ovf",   int'(ovf),   1);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_tc",  int'(tc),  0);

    cyc(0, 0, 1, 9, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 1);
    chk("setwin_count", int'(count), 0);
    chk("setwin_tc",    int'(tc),    1);
    chk("setwin_ovf",   int'(ovf),   1);
`endif

    cyc(0, 0, 1, 5, 1, 0, 0);
    cyc(1, 1, 1, 7, 1, 0, 0);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_tc",    int'(tc),    0);
    chk("rstmid_ovf",   int'(ovf),   0);

    // randomized traffic; direction and mode change occasionally
    begin
      bit u = 1, s = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 9) == 0) u = ~u;
        if ($urandom_range(0, 19) == 0) s = ~s;
        cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
            u, s, $urandom_range(0, 9) == 0);
      end
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
